// File: rtl/pipelined_csel_adder_pkg.sv
// Shared helpers for the pipelined carry-select adder: stage count and a one-bit full adder.
package pipelined_csel_adder_pkg;

    function automatic int num_stages(input int width, input int block, input int blocks_per_stage);
        int groups;
        groups = width / block;
        return (groups + blocks_per_stage - 1) / blocks_per_stage;
    endfunction

    // Returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/pipelined_csel_adder_csel_block.sv
// One carry-select group: two ripple chains (carry-in 0 and 1) and a per-bit select on the real carry.
module csel_block
    import pipelined_csel_adder_pkg::*;
#(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK-1:0] sum0;
    logic [BLOCK-1:0] sum1;
    logic [BLOCK:0]   carry0;
    logic [BLOCK:0]   carry1;

    always_comb begin
        sum0   = '0;
        sum1   = '0;
        carry0 = '0;
        carry1 = '0;
        carry1[0] = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            {carry0[i+1], sum0[i]} = full_add(a[i], b[i], carry0[i]);
            {carry1[i+1], sum1[i]} = full_add(a[i], b[i], carry1[i]);
        end
    end

    assign sum  = cin ? sum1 : sum0;
    assign cout = cin ? carry1[BLOCK] : carry0[BLOCK];

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready on both sides.
// Each stage resolves BLOCKS_PER_STAGE groups and forwards only the operand bits still to be added.
module pipelined_csel_adder
    import pipelined_csel_adder_pkg::*;
#(
    parameter int WIDTH            = 64,
    parameter int BLOCK            = 8,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] num1_i,
    input  logic [WIDTH-1:0] num2_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int NUM_GROUPS = WIDTH / BLOCK;
    localparam int NUM_STAGES = num_stages(WIDTH, BLOCK, BLOCKS_PER_STAGE);
    localparam int STAGE_BITS = BLOCK * BLOCKS_PER_STAGE;
    localparam int LAST_LO    = (NUM_STAGES - 1) * STAGE_BITS;

    if (BLOCK < 1 || BLOCKS_PER_STAGE < 1 || NUM_GROUPS * BLOCK != WIDTH) begin : gen_bad_params
        $error("pipelined_csel_adder: WIDTH must be a multiple of BLOCK, BLOCK and BLOCKS_PER_STAGE >= 1");
    end

    logic adv;
    logic ovf_q;
    logic a_msb;
    logic b_msb;

    assign adv     = ready_i | ~valid_o;
    assign ready_o = adv;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : gen_stg
        localparam int LO   = s * STAGE_BITS;
        localparam int HI   = (((s + 1) * STAGE_BITS < WIDTH) ? (s + 1) * STAGE_BITS : WIDTH) - 1;
        localparam int NG   = (HI - LO + 1) / BLOCK;
        localparam bit LAST = (s == NUM_STAGES - 1);

        logic               in_v;
        logic               in_c;
        logic [WIDTH-LO-1:0] in_a;
        logic [WIDTH-LO-1:0] in_b;
        wire  [HI-LO:0]     grp_sum;
        logic [HI:0]        sum_d;
        logic               st_cout;
        logic               q_v;
        logic               q_c;
        logic [HI:0]        q_sum;

        if (s == 0) begin : gen_in
            assign in_v  = valid_i & adv;
            assign in_a  = num1_i;
            assign in_b  = sub_i ? ~num2_i : num2_i;
            assign in_c  = sub_i | carry_i;
            assign sum_d = grp_sum;
        end else begin : gen_in
            assign in_v  = gen_stg[s-1].q_v;
            assign in_c  = gen_stg[s-1].q_c;
            assign in_a  = gen_stg[s-1].gen_fwd.q_a;
            assign in_b  = gen_stg[s-1].gen_fwd.q_b;
            assign sum_d = {grp_sum, gen_stg[s-1].q_sum};
        end

        for (genvar j = 0; j < NG; j++) begin : gen_grp
            logic             cin;
            logic             cout;
            logic [BLOCK-1:0] sum;

            if (j == 0) begin : gen_c0
                assign cin = in_c;
            end else begin : gen_cn
                assign cin = gen_grp[j-1].cout;
            end

            csel_block #(.BLOCK(BLOCK)) u_blk (
                .a    (in_a[j*BLOCK +: BLOCK]),
                .b    (in_b[j*BLOCK +: BLOCK]),
                .cin  (cin),
                .sum  (sum),
                .cout (cout)
            );

            assign grp_sum[j*BLOCK +: BLOCK] = sum;
        end

        assign st_cout = gen_grp[NG-1].cout;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                q_v   <= 1'b0;
                q_c   <= 1'b0;
                q_sum <= '0;
            end else if (adv) begin
                q_v   <= in_v;
                q_c   <= st_cout;
                q_sum <= sum_d;
            end
        end

        // Only the operand bits above this stage travel on.
        if (!LAST) begin : gen_fwd
            logic [WIDTH-HI-2:0] q_a;
            logic [WIDTH-HI-2:0] q_b;

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    q_a <= '0;
                    q_b <= '0;
                end else if (adv) begin
                    q_a <= in_a[WIDTH-LO-1:HI-LO+1];
                    q_b <= in_b[WIDTH-LO-1:HI-LO+1];
                end
            end
        end
    end

    assign a_msb = gen_stg[NUM_STAGES-1].in_a[WIDTH-LAST_LO-1];
    assign b_msb = gen_stg[NUM_STAGES-1].in_b[WIDTH-LAST_LO-1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= (a_msb == b_msb) & (gen_stg[NUM_STAGES-1].sum_d[WIDTH-1] != a_msb);
        end
    end

    assign valid_o    = gen_stg[NUM_STAGES-1].q_v;
    assign sum_o      = gen_stg[NUM_STAGES-1].q_sum;
    assign carry_o    = gen_stg[NUM_STAGES-1].q_c;
    assign overflow_o = ovf_q;

endmodule

// File: doc/pipelined_csel_adder.md
Name: pipelined_csel_adder

Overview:
Parametrised, pipelined carry-select adder/subtractor. It is the successor to the fixed 64-bit combinational carry-select adder. Operands are split into BLOCK-bit groups; each group computes both carry hypotheses and a mux picks the result. Pipeline registers sit every BLOCKS_PER_STAGE groups, with a valid/ready handshake on both sides. It is used as the adder datapath in the arithmetic-method comparison blocks, and wherever a timed, back-pressurable adder is needed.

Parameters:
WIDTH, 64, operand/result width in bits; must be a multiple of BLOCK
BLOCK, 8, bits per carry-select group
BLOCKS_PER_STAGE, 2, groups evaluated between pipeline registers; NUM_STAGES = ceil((WIDTH/BLOCK)/BLOCKS_PER_STAGE)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  synchronous active-low reset
valid_i  input  1  operand beat valid
ready_o  output  1  block can accept a beat this cycle
num1_i  input  WIDTH  operand A
num2_i  input  WIDTH  operand B
carry_i  input  1  carry-in; ignored when sub_i=1
sub_i  input  1  0: A+B+carry_i; 1: A-B (A+~B+1)
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result
sum_o  output  WIDTH  result, modulo 2^WIDTH
carry_o  output  1  carry-out of MSB; for subtract, 1 = no borrow
overflow_o  output  1  two's-complement signed overflow

Behaviour:
- Reset: sampled on rising clk_i while rst_ni=0. It clears all stage valid bits, valid_o=0, sum_o=0, carry_o=0, overflow_o=0. In-flight beats are discarded. Reset dominates any handshake in the same cycle.
- Advance rule: adv = ready_i | ~valid_o. ready_o = adv (combinational from ready_i and valid_o). On adv=1 every stage register shifts forward one position. On adv=0 every stage holds, including the output register.
- Accept when valid_i & ready_o. A non-accepted cycle injects a bubble (valid bit 0). Bubbles are not collapsed.
- Latency: result appears at the outputs exactly NUM_STAGES cycles after acceptance when not stalled. Defaults give NUM_STAGES=4. Throughput is 1 beat/cycle when ready_i stays high.
- Stage k evaluates groups k*BLOCKS_PER_STAGE up to min(next, WIDTH/BLOCK)-1:
  - For each group, compute sum0/carry0 (cin=0) and sum1/carry1 (cin=1) by ripple.
  - Select with the incoming group carry, which feeds the next group.
- Stage registers hold: valid bit, the partial sum computed so far, the carry into the next group, the unprocessed upper operand bits (B already inverted if sub), and the A/B MSBs needed for overflow.
- Operand conditioning at stage 0: B' = sub_i ? ~num2_i : num2_i; cin = sub_i ? 1 : carry_i.
- overflow_o = (A[WIDTH-1] == B'[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]).
- Outputs change only on an adv edge. While valid_o=1 & ready_i=0, sum_o/carry_o/overflow_o stay stable.
- Elaboration error if WIDTH%BLOCK != 0, BLOCK < 1, or BLOCKS_PER_STAGE < 1. A partial last stage (fewer groups) is legal.

Decomposition:
- No shared package is required. Derived localparams (NUM_GROUPS, NUM_STAGES) are computed locally. If the project arithmetic package exists, put NUM_STAGES as a function there for reuse by the benches.
- Sub-module csel_block:
  - Parameter BLOCK.
  - Inputs: a, b, cin. Outputs: sum, cout.
  - Two ripple chains of the existing fulladder, plus a per-bit multiplexer driven by cin.
  - Purely combinational. Instantiated NUM_GROUPS times under generate.

Test Plan:
- Defaults, ready_i=1: A=0xFFFF_FFFF_FFFF_FFFF, B=1, carry_i=0, sub_i=0 -> 4 cycles later sum_o=0, carry_o=1, overflow_o=0, valid_o pulse 1 cycle.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> sum_o=0x8000_0000_0000_0000, carry_o=0, overflow_o=1. Subtract A=5, B=7, sub_i=1 -> sum_o=0xFFFF_FFFF_FFFF_FFFE, carry_o=0, overflow_o=0.
- Back-to-back streaming: 16 random beats with valid_i held high and ready_i=1 -> 16 results in order, consecutive cycles, each matching a reference model A+B+cin.
- Backpressure: ready_i=0, valid_i held high with beats 1..6 -> exactly 4 accepted, ready_o low from the cycle valid_o rises, and sum_o held stable. Then ready_i=1 -> results 1..4 in order, and beats 5 and 6 are then accepted.
- Reset mid-operation: accept 3 beats, assert rst_ni=0 for 1 cycle -> valid_o=0 and all outputs 0 next cycle. No stale results ever emerge, and the next accepted beat returns after 4 cycles.
- Parameter sweep (WIDTH,BLOCK,BLOCKS_PER_STAGE) = (16,4,1), (32,8,3), (64,16,4) -> latency equals the computed NUM_STAGES, and 1000 random add/sub beats match the model.
